// File: rtl/arb_pkg.sv
// Shared types, sizes and helpers for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Next priority position after idx, wrapping N_REQ-1 -> 0.
    function automatic logic [IDX_W-1:0] ptr_next(input logic [IDX_W-1:0] idx);
        return idx + IDX_W'(1);
    endfunction

    // First set request scanning ptr, ptr+1, ... with wrap. Scanning the offsets from
    // the far end down lets the closest-to-ptr candidate overwrite the others.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] win;
        win = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                win = cand;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/dec3to8_en.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when disabled.
module dec3to8_en
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] onehot
);

    // Decode the index into a single set bit, gated by the enable.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with hold limit and one-cycle idle bubble between grants.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;

    logic rel_done;
    logic rel_drop;
    logic rel_limit;

    // Release causes only matter while in GRANT.
    assign rel_done  = done;
    assign rel_drop  = ~req[idx_q];
    assign rel_limit = (hold_q == CNT_W'(HOLD_MAX - 1));

    // Next-state: pick a winner from IDLE, count/release while granted.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_GRANT;
                    idx_d   = rr_pick(req, ptr_q);
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                if (rel_done || rel_drop || rel_limit) begin
                    state_d   = ST_IDLE;
                    idx_d     = '0;
                    hold_d    = '0;
                    ptr_d     = ptr_next(idx_q);
                    // A limit hit that coincides with a normal release is not a revoke.
                    timeout_d = rel_limit & ~rel_done & ~rel_drop;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_valid = (state_q == ST_GRANT);
    assign gnt_idx   = idx_q;
    assign timeout   = timeout_q;

    dec3to8_en u_dec (
        .idx    (idx_q),
        .en     (gnt_valid),
        .onehot (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8 (HOLD_MAX=16).
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_checks;
    int n_fail;

    rr_arbiter8 #(
        .HOLD_MAX (16),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare all four outputs against expected values.
    task automatic expect_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_idx,
                              input logic e_valid, input logic e_to);
        check_eq({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        check_eq({tag, ".idx"}, 32'(gnt_idx), 32'(e_idx));
        check_eq({tag, ".valid"}, 32'(gnt_valid), 32'(e_valid));
        check_eq({tag, ".timeout"}, 32'(timeout), 32'(e_to));
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req      = 8'h00;
        done     = 1'b0;

        // Idle with no requests.
        do_reset();
        expect_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out($sformatf("idle%0d", i), 8'h00, 3'd0, 1'b0, 1'b0);
        end

        // Two requesters, done release, then pointer moves past 2.
        do_reset();
        req = 8'b0010_0100;
        tick();
        expect_out("b_first", 8'h04, 3'd2, 1'b1, 1'b0);
        tick();
        tick();
        expect_out("b_hold", 8'h04, 3'd2, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        expect_out("b_rel", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        expect_out("b_second", 8'h20, 3'd5, 1'b1, 1'b0);

        // All requesting: strict cyclic order with one bubble between grants.
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            tick();
            expect_out($sformatf("c_gnt%0d", k), 8'(1 << (k % 8)), 3'(k % 8), 1'b1, 1'b0);
            done = 1'b1;
            tick();
            done = 1'b0;
            expect_out($sformatf("c_gap%0d", k), 8'h00, 3'd0, 1'b0, 1'b0);
        end

        // Sole requester 7 held past the limit: 16 grant cycles, timeout, re-grant.
        do_reset();
        req = 8'h80;
        tick();
        expect_out("d_h0", 8'h80, 3'd7, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) begin
            tick();
            expect_out($sformatf("d_h%0d", i), 8'h80, 3'd7, 1'b1, 1'b0);
        end
        tick();
        expect_out("d_timeout", 8'h00, 3'd0, 1'b0, 1'b1);
        tick();
        expect_out("d_regrant", 8'h80, 3'd7, 1'b1, 1'b0);
        // done coinciding with the limit is a normal release.
        for (int i = 1; i < 16; i++) tick();
        expect_out("d_last", 8'h80, 3'd7, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        expect_out("d_coincide", 8'h00, 3'd0, 1'b0, 1'b0);

        // Owner 3 drops its request; non-owner changes are ignored meanwhile.
        do_reset();
        req = 8'h48;
        tick();
        expect_out("e_first", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h0A;
        tick();
        expect_out("e_other", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h40;
        tick();
        expect_out("e_drop", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        expect_out("e_next", 8'h40, 3'd6, 1'b1, 1'b0);

        // Reset mid-grant clears pointer and outputs.
        do_reset();
        req = 8'h81;
        tick();
        expect_out("f_g0", 8'h01, 3'd0, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        expect_out("f_g7", 8'h80, 3'd7, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        expect_out("f_h9", 8'h80, 3'd7, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("f_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        expect_out("f_after", 8'h01, 3'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
